aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
- Round-key source for the AES-128 decryption datapath.
- Accepts the master key and runs the forward schedule internally, one round per cycle, to reach the round-10 key.
- Then emits round keys in reverse order, 10 down to 0, over a valid/ready handshake, using the inverse key recurrence. No 44-word key store is kept.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches key_in; honoured only in IDLE
- key_in  input  128  master key (round-0 key), word 0 in [127:96]
- busy  output  1  high from the cycle after an accepted start until the cycle after the final handshake
- key_valid  output  1  round_key/round valid for the consumer
- key_ready  input  1  consumer accepts the current key when key_valid && key_ready
- round  output  4  round index of round_key, 10 down to 0
- round_key  output  128  current round key, word 0 in [127:96]
- done  output  1  one-cycle pulse in the cycle after round 0 is accepted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, key_valid=0, done=0, round=0, round_key=0; internal key register and counter cleared. Reset mid-operation abandons the schedule; no partial output follows.
- States: IDLE, FWD, REV.
- IDLE:
  - start=1 → key register = key_in, fwd counter r=1, state=FWD, busy=1.
  - start=0 → stay in IDLE.
- FWD, one round per cycle. Current key K=(a,b,c,d), t = SubWord(RotWord(d)) ^ Rcon(r).
  - Next key: a'=a^t, b'=b^a', c'=c^b', d'=d^c'.
  - Rcon(r) = {01,02,04,08,10,20,40,80,1B,36}[r-1] in the top byte; lower 24 bits are zero.
  - After the r=10 update: state=REV, round=10, round_key=K10, key_valid=1.
- Latency: start accepted at edge 0 → key_valid first high after edge 10.
- REV:
  - key_valid stays high.
  - round_key and round stay stable while key_ready=0, for an unbounded stall.
  - On handshake with round>0, compute the previous key from (a,b,c,d) = K_round:
    - d_p=d^c, c_p=c^b, b_p=b^a
    - a_p = a ^ SubWord(RotWord(d_p)) ^ Rcon(round)
    - round decrements. key_valid stays high, so one key per cycle is sustained while key_ready=1.
  - On handshake with round==0: key_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- start outside IDLE, including the final-handshake cycle, is ignored. A new start is accepted from the cycle done is high onward.
- key_ready is ignored while key_valid=0.
- SubWord hardware: four S-box instances only, shared between FWD and REV.
  - Input mux: RotWord(d) in FWD, RotWord(d^c) in REV.
  - The REV path is combinational from the key register within one cycle.
- Word order: word 0 = MSW, RotWord = {w[23:0], w[31:24]}, matching the forward expander.
- No simulation $display output in this block.

Decomposition:
- Shared include aes_defs.vh:
  - state encodings
  - Rcon table as a function indexed by round 1..10
  - AES_NR=10
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4×. Reused by the encryption-side SubBytes and the forward expander.
- Sub-module aes_rcon: not required; the function in aes_defs.vh is sufficient.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready tied 1 → key_valid rises 10 cycles after start.
  - Keys in order: d014f9a8c9ee2589e13f0cc8b6630ca6 (r10), ac7766f319fadc2128d12941575c006e (r9), … , a0fafe1788542cb123a339392a6c7605 (r1), 2b7e1516…4f3c (r0).
  - 11 consecutive valid cycles; done one cycle after r0.
- All-zero key → r10 = b4ef5bcb3e92e21123e951cf6f8f188e, r1 = 62636363626363636263636362636363, r0 = 0.
- Backpressure: key_ready low for 5 cycles at round 7 → round=7 and round_key held bit-stable throughout. Resume yields round 6 the cycle after ready returns.
- start pulsed during FWD and again during REV with a different key → ignored; output sequence identical to the unperturbed run.
- rst_n low mid-REV (round 4) → all outputs 0 immediately. A subsequent start yields a full correct 10..0 sequence.
- Back-to-back: start asserted in the done cycle with a new key → accepted. Second sequence correct, no stale keys from the first.

Source files
------------

// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared definitions for the AES-128 round-key source: schedule states,
// round-constant lookup and the word rotation used by both schedule directions.
package aes_inv_key_schedule_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } state_e;

    // Rcon(r) top byte for r = 1..10; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Table entry 0 sits in the top byte, so the index is the inverted input scaled by 8.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption round-key source: expands forward to K10 one round per cycle,
// then streams K10..K0 over valid/ready, walking back with the inverse recurrence.
module aes_inv_key_schedule
    import aes_inv_key_schedule_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         done
);

    state_e         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           done_q, done_d;

    logic [31:0] w_a, w_b, w_c, w_d;
    logic [31:0] sub_in, sub_out, t_word;
    logic [31:0] f_a, f_b, f_c, f_d;
    logic [31:0] r_d;

    assign w_a = key_q[127:96];
    assign w_b = key_q[95:64];
    assign w_c = key_q[63:32];
    assign w_d = key_q[31:0];

    // The four S-boxes are shared: FWD feeds d, REV feeds the recovered d_p = d ^ c.
    assign r_d    = w_d ^ w_c;
    assign sub_in = (state_q == ST_REV) ? rot_word(r_d) : rot_word(w_d);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sub_in[8*i +: 8]),
            .out_o (sub_out[8*i +: 8])
        );
    end

    assign t_word = sub_out ^ {rcon(rnd_q), 24'h000000};

    assign f_a = w_a ^ t_word;
    assign f_b = w_b ^ f_a;
    assign f_c = w_c ^ f_b;
    assign f_d = w_d ^ f_c;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    rnd_d   = 4'd1;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                key_d = {f_a, f_b, f_c, f_d};
                // Counter parks at NR so it doubles as the first output round index.
                if (rnd_q == 4'(NR)) begin
                    state_d = ST_REV;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ST_REV: begin
                if (key_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = {w_a ^ t_word, w_a ^ w_b, w_b ^ w_c, r_d};
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign key_valid = (state_q == ST_REV);
    assign round     = rnd_q;
    assign round_key = key_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule; a forward-expansion reference model
// with an arithmetic S-box fills a scoreboard that is drained on every handshake.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         key_valid;
    logic         key_ready = 1'b1;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         done;

    int n_asrt = 0;
    int n_fail = 0;
    logic [131:0] sb[$];
    logic exp_done = 1'b0;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ALT  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_B2B  = 128'hdeadbeef0123456789abcdeffedcba98;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round     (round),
        .round_key (round_key),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        if (x != 8'h00)
            for (int i = 1; i < 256; i++)
                if (gmul(x, 8'(i)) == 8'h01) v = 8'(i);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword_m(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    task automatic push_expected(input logic [127:0] k);
        logic [127:0] ks[0:10];
        logic [31:0]  a, b, c, d, t;
        logic [7:0]   rc = 8'h01;
        ks[0] = k;
        for (int r = 1; r <= 10; r++) begin
            {a, b, c, d} = ks[r-1];
            t = subword_m({d[23:0], d[31:24]}) ^ {rc, 24'h0};
            a ^= t; b ^= a; c ^= b; d ^= c;
            ks[r] = {a, b, c, d};
            rc = xt(rc);
        end
        for (int r = 10; r >= 0; r--) sb.push_back({4'(r), ks[r]});
    endtask

    // Called at posedge+1: the next rising edge samples start.
    task automatic start_key(input logic [127:0] k);
        push_expected(k);
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin lat = i; break; end
        end
        chk("valid_timeout", {127'd0, key_valid}, 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        for (int i = 0; i < 40; i++) begin
            if (key_valid && round == r) break;
            @(posedge clk); #1;
        end
        chk("round_reach", {123'd0, key_valid, round}, {123'd0, 1'b1, r});
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin cyc = i; break; end
        end
        chk("done_timeout", {127'd0, done}, 128'd1);
    endtask

    always @(negedge clk) begin
        logic [131:0] e;
        if (!rst_n) exp_done = 1'b0;
        chk("done_pulse", {127'd0, done}, {127'd0, exp_done});
        exp_done = 1'b0;
        if (rst_n && key_valid && key_ready) begin
            chk("sb_nonempty", {127'd0, sb.size() != 0}, 128'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_round", {124'd0, round}, {124'd0, e[131:128]});
                chk("sb_key", round_key, e[127:0]);
            end
            exp_done = (round == 4'd0);
        end
    end

    initial begin
        int lat, cyc;
        logic [127:0] held;

        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy",  {127'd0, busy}, 128'd0);
        chk("rst_valid", {127'd0, key_valid}, 128'd0);
        chk("rst_done",  {127'd0, done}, 128'd0);
        chk("rst_round", {124'd0, round}, 128'd0);
        chk("rst_key",   round_key, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 key, ready held high
        start_key(K_FIPS);
        chk("busy_after_start", {127'd0, busy}, 128'd1);
        wait_valid(lat);
        chk("latency", 128'(lat), 128'd10);
        chk("fips_r10_idx", {124'd0, round}, 128'd10);
        chk("fips_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(posedge clk); #1;
        chk("fips_r9_idx", {124'd0, round}, 128'd9);
        chk("fips_r9", round_key, 128'hac7766f319fadc2128d12941575c006e);
        wait_round(4'd1);
        chk("fips_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        wait_done(cyc);
        chk("stream_len", 128'(cyc), 128'd2);
        chk("busy_at_done", {127'd0, busy}, 128'd0);
        chk("valid_at_done", {127'd0, key_valid}, 128'd0);

        // All-zero key
        start_key(128'd0);
        wait_valid(lat);
        chk("zero_r10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        wait_round(4'd1);
        chk("zero_r1", round_key, 128'h62636363626363636263636362636363);
        @(posedge clk); #1;
        chk("zero_r0_idx", {124'd0, round}, 128'd0);
        chk("zero_r0", round_key, 128'd0);
        wait_done(cyc);

        // Backpressure at round 7
        start_key(K_ALT);
        wait_round(4'd7);
        key_ready = 1'b0;
        held = round_key;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_round", {124'd0, round}, 128'd7);
            chk("stall_key", round_key, held);
            chk("stall_valid", {127'd0, key_valid}, 128'd1);
        end
        key_ready = 1'b1;
        @(posedge clk); #1;
        chk("resume_round", {124'd0, round}, 128'd6);
        wait_done(cyc);

        // Stray starts in FWD, REV and the final-handshake cycle
        start_key(K_FIPS);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; key_in = K_ALT;
        @(posedge clk); #1 start = 1'b0;
        wait_round(4'd5);
        start = 1'b1; key_in = K_B2B;
        @(posedge clk); #1 start = 1'b0;
        wait_round(4'd0);
        start = 1'b1; key_in = K_ALT;
        @(posedge clk); #1 start = 1'b0;
        chk("final_done", {127'd0, done}, 128'd1);
        chk("final_busy", {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        chk("start_ignored", {127'd0, busy}, 128'd0);

        // Reset mid-REV
        start_key(K_B2B);
        wait_round(4'd4);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy",  {127'd0, busy}, 128'd0);
        chk("mrst_valid", {127'd0, key_valid}, 128'd0);
        chk("mrst_round", {124'd0, round}, 128'd0);
        chk("mrst_key",   round_key, 128'd0);
        sb.delete();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_quiet", {126'd0, key_valid, done}, 128'd0);
        start_key(K_B2B);
        wait_done(cyc);

        // Back-to-back: new start in the done cycle
        start_key(K_ALT);
        wait_done(cyc);
        start_key(K_FIPS);
        chk("b2b_busy", {127'd0, busy}, 128'd1);
        wait_valid(lat);
        chk("b2b_latency", 128'(lat), 128'd10);
        wait_done(cyc);
        @(posedge clk); #1;

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
